// File: rtl/cache_bus_arbiter.sv
// 2:1 arbiter sharing the single SRAM-like cache-to-AXI port between i_cache and d_cache.
// One transaction in flight; data wins ties, but a run counter forces an inst grant after MAX_DATA_RUN.
module cache_bus_arbiter #(
    parameter int unsigned MAX_DATA_RUN = 4,
    parameter int unsigned CNT_WIDTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req_i,
    input  logic        inst_wr_i,
    input  logic [1:0]  inst_size_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] inst_wdata_i,
    output logic [31:0] inst_rdata_o,
    output logic        inst_addr_ok_o,
    output logic        inst_data_ok_o,
    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_size_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_addr_ok_o,
    output logic        data_data_ok_o,
    output logic        bus_req_o,
    output logic        bus_wr_o,
    output logic [1:0]  bus_size_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_addr_ok_i,
    input  logic        bus_data_ok_i,
    output logic [1:0]  dbg_state_o,
    output logic        dbg_owner_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] RUN_LIMIT = CNT_WIDTH'(MAX_DATA_RUN);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;   // 0 = inst, 1 = data
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sel_data;
    logic                 owner_req;
    logic                 run_limit_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outside IDLE the owner's fields stay on the bus so the bridge sees stable values through WAIT.
    assign sel_data      = (state_q != IDLE) && owner_q;
    assign owner_req     = sel_data ? data_req_i : inst_req_i;
    assign run_limit_hit = inst_req_i && (cnt_q == RUN_LIMIT);

    assign bus_wr_o     = sel_data ? data_wr_i    : inst_wr_i;
    assign bus_size_o   = sel_data ? data_size_i  : inst_size_i;
    assign bus_addr_o   = sel_data ? data_addr_i  : inst_addr_i;
    assign bus_wdata_o  = sel_data ? data_wdata_i : inst_wdata_i;
    assign inst_rdata_o = bus_rdata_i;
    assign data_rdata_o = bus_rdata_i;
    assign dbg_state_o  = state_q;
    assign dbg_owner_o  = owner_q;

    // Handshake: a master holds req until its addr_ok; the address transfers on a cycle with
    // bus_req_o && bus_addr_ok_i; data_ok is a one-cycle completion strobe qualifying rdata.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        cnt_d          = cnt_q;
        bus_req_o      = 1'b0;
        inst_addr_ok_o = 1'b0;
        data_addr_ok_o = 1'b0;
        inst_data_ok_o = 1'b0;
        data_data_ok_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (data_req_i && !run_limit_hit) begin
                    owner_d = 1'b1;
                    state_d = ADDR;
                    if (!inst_req_i)
                        cnt_d = '0;
                    else if (cnt_q != CNT_MAX)
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                end else if (inst_req_i) begin
                    owner_d = 1'b0;
                    state_d = ADDR;
                    cnt_d   = '0;
                end
            end
            ADDR: begin
                bus_req_o = owner_req;
                if (!owner_req) begin
                    state_d = IDLE;
                end else if (bus_addr_ok_i) begin
                    state_d        = WAIT;
                    inst_addr_ok_o = !owner_q;
                    data_addr_ok_o = owner_q;
                end
            end
            WAIT: begin
                if (bus_data_ok_i) begin
                    state_d        = IDLE;
                    inst_data_ok_o = !owner_q;
                    data_data_ok_o = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            bus_req_o      = 1'b0;
            inst_addr_ok_o = 1'b0;
            data_addr_ok_o = 1'b0;
            inst_data_ok_o = 1'b0;
            data_data_ok_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Bench for cache_bus_arbiter: scenario tasks with inline checks, plus a scoreboard that pops
// expected grants and read data whenever the arbiter issues an addr_ok or data_ok.
module tb_cache_bus_arbiter;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = 2'd0;
    logic [31:0] inst_addr = '0, inst_wdata = '0;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
    logic [1:0]  dbg_state;
    logic        dbg_owner;

    logic [67:0] exp_q[$];
    logic [31:0] rd_q[$];
    logic        cur_owner = 1'b0;
    int          n_checks = 0, n_fail = 0;
    int          n_data_hs = 0, n_inst_hs = 0, n_done = 0;

    logic        bridge_en = 1'b0, br_busy = 1'b0;
    int          br_cnt = 0, br_acnt = 0;

    cache_bus_arbiter #(.MAX_DATA_RUN(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req), .inst_wr_i(inst_wr), .inst_size_i(inst_size),
        .inst_addr_i(inst_addr), .inst_wdata_i(inst_wdata), .inst_rdata_o(inst_rdata),
        .inst_addr_ok_o(inst_addr_ok), .inst_data_ok_o(inst_data_ok),
        .data_req_i(data_req), .data_wr_i(data_wr), .data_size_i(data_size),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_rdata_o(data_rdata),
        .data_addr_ok_o(data_addr_ok), .data_data_ok_o(data_data_ok),
        .bus_req_o(bus_req), .bus_wr_o(bus_wr), .bus_size_o(bus_size),
        .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata),
        .bus_addr_ok_i(bus_addr_ok), .bus_data_ok_i(bus_data_ok),
        .dbg_state_o(dbg_state), .dbg_owner_o(dbg_owner)
    );

    always #5 clk = ~clk;

    function automatic logic [67:0] mk(input logic own, input logic wr, input logic [1:0] sz,
                                       input logic [31:0] a, input logic [31:0] wd);
        return {own, wr, sz, a, wd};
    endfunction

    // Scoreboard: runs at the falling edge, after inputs for the cycle have settled.
    task automatic sample();
        logic [67:0] e, got;
        logic [31:0] r, got_rd;
        @(negedge clk);
        if (rst) return;
        if (inst_addr_ok || data_addr_ok) begin
            n_checks++;
            got = {data_addr_ok, bus_wr, bus_size, bus_addr, bus_wdata};
            if (inst_addr_ok && data_addr_ok) begin
                n_fail++;
                $display("FAIL addr_ok_onehot: inst=%b data=%b, required only one", inst_addr_ok, data_addr_ok);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL addr_ok_unexpected: got %h, required no handshake", got);
            end else begin
                e = exp_q.pop_front();
                cur_owner = e[67];
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL grant_order: got %h, required %h", got, e);
                end
            end
            if (data_addr_ok) n_data_hs++;
            else n_inst_hs++;
        end
        if (inst_data_ok || data_data_ok) begin
            n_checks++;
            got_rd = data_data_ok ? data_rdata : inst_rdata;
            if (inst_data_ok && data_data_ok) begin
                n_fail++;
                $display("FAIL data_ok_onehot: inst=%b data=%b, required only one", inst_data_ok, data_data_ok);
            end else if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL data_ok_unexpected: got %h, required no completion", got_rd);
            end else begin
                r = rd_q.pop_front();
                if ({data_data_ok, got_rd} !== {cur_owner, r}) begin
                    n_fail++;
                    $display("FAIL read_return: got owner=%b data=%h, required owner=%b data=%h",
                             data_data_ok, got_rd, cur_owner, r);
                end
            end
            n_done++;
        end
    endtask

    // Advances to just after the next rising edge and lets the automatic bridge respond.
    task automatic next();
        @(posedge clk);
        #1;
        if (bridge_en) begin
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            if (br_busy) begin
                if (br_cnt == 0) begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = $urandom;
                    rd_q.push_back(bus_rdata);
                    br_busy = 1'b0;
                    br_acnt = $urandom_range(0, 2);
                end else begin
                    br_cnt--;
                end
            end else if (bus_req) begin
                if (br_acnt == 0) begin
                    bus_addr_ok = 1'b1;
                    br_busy     = 1'b1;
                    br_cnt      = $urandom_range(0, 2);
                end else begin
                    br_acnt--;
                end
            end
        end
    endtask

    task automatic step();
        sample();
        next();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        inst_req = 1'b0; data_req = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        bridge_en = 1'b0; br_busy = 1'b0; br_acnt = 0;
        next();
        next();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        data_req = 1'b1; data_addr = 32'h0000_0040;
        step();
        rst = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1; inst_req = 1'b1;
        sample();
        n_checks++;
        if ({bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 00000",
                     {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        end
        next();
        rst = 1'b0; inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        sample();
        n_checks++;
        if ({dbg_state, dbg_owner, bus_req, data_addr_ok, data_data_ok} !== {S_IDLE, 4'b0}) begin
            n_fail++;
            $display("FAIL reset_after: got state=%0d owner=%b req=%b, required IDLE/0/0", dbg_state, dbg_owner, bus_req);
        end
        next();
        sample();
        n_checks++;
        if ({dbg_state, dbg_owner, bus_req, bus_addr} !== {S_ADDR, 1'b1, 1'b1, 32'h0000_0040}) begin
            n_fail++;
            $display("FAIL reset_first_grant: got state=%0d owner=%b req=%b addr=%h, required ADDR/1/1/00000040",
                     dbg_state, dbg_owner, bus_req, bus_addr);
        end
        next();
        data_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_data_read();
        apply_reset();
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_1000; data_wdata = $urandom;
        exp_q.push_back(mk(1'b1, 1'b0, 2'd2, 32'h0000_1000, data_wdata));
        sample();
        n_checks++;
        if ({dbg_state, bus_req, data_addr_ok} !== {S_IDLE, 2'b00}) begin
            n_fail++;
            $display("FAIL read_latency: got state=%0d req=%b, required IDLE/0", dbg_state, bus_req);
        end
        next();
        bus_addr_ok = 1'b1;
        sample();
        n_checks++;
        if ({dbg_state, bus_req, data_addr_ok, inst_addr_ok} !== {S_ADDR, 3'b110}) begin
            n_fail++;
            $display("FAIL read_addr_ok: got state=%0d req=%b d=%b i=%b, required ADDR/1/1/0",
                     dbg_state, bus_req, data_addr_ok, inst_addr_ok);
        end
        next();
        bus_addr_ok = 1'b0; data_req = 1'b0;
        sample();
        n_checks++;
        if ({dbg_state, bus_req, bus_addr, data_data_ok} !== {S_WAIT, 1'b0, 32'h0000_1000, 1'b0}) begin
            n_fail++;
            $display("FAIL read_wait: got state=%0d req=%b addr=%h dok=%b, required WAIT/0/00001000/0",
                     dbg_state, bus_req, bus_addr, data_data_ok);
        end
        next();
        bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        rd_q.push_back(32'hDEAD_BEEF);
        sample();
        n_checks++;
        if ({data_data_ok, inst_data_ok, data_rdata, inst_rdata} !== {2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL read_data_ok: got dok=%b iok=%b drd=%h ird=%h, required 1/0/deadbeef/deadbeef",
                     data_data_ok, inst_data_ok, data_rdata, inst_rdata);
        end
        next();
        bus_data_ok = 1'b0;
        sample();
        n_checks++;
        if (dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL read_return_idle: got state=%0d, required %0d", dbg_state, S_IDLE);
        end
        next();
    endtask

    task automatic test_simultaneous();
        int  base_d, base_i, base_done;
        logic hit;
        apply_reset();
        bridge_en = 1'b1;
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h0000_2000; inst_wdata = $urandom;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h0000_3000; data_wdata = $urandom;
        exp_q.push_back(mk(1'b1, 1'b1, 2'd1, 32'h0000_3000, data_wdata));
        exp_q.push_back(mk(1'b0, 1'b0, 2'd2, 32'h0000_2000, inst_wdata));
        base_d = n_data_hs; base_i = n_inst_hs; base_done = n_done; hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            sample();
            hit = data_data_ok;
            next();
            if (n_data_hs > base_d) data_req = 1'b0;
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL simul_timeout: got no data_data_ok in 40 cycles, required one");
        end
        sample();
        n_checks++;
        if (dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL simul_idle_gap: got state=%0d, required %0d", dbg_state, S_IDLE);
        end
        next();
        sample();
        n_checks++;
        if ({dbg_state, bus_req, bus_addr} !== {S_ADDR, 1'b1, 32'h0000_2000}) begin
            n_fail++;
            $display("FAIL simul_inst_grant: got state=%0d req=%b addr=%h, required ADDR/1/00002000",
                     dbg_state, bus_req, bus_addr);
        end
        next();
        for (int i = 0; i < 40 && (n_done - base_done) < 2; i++) begin
            if (n_inst_hs > base_i) inst_req = 1'b0;
            step();
        end
        inst_req = 1'b0;
        n_checks++;
        if ((n_done - base_done) !== 2) begin
            n_fail++;
            $display("FAIL simul_done: got %0d completions, required 2", n_done - base_done);
        end
        step();
    endtask

    task automatic test_starvation();
        int base_hs, base_i, base_done;
        apply_reset();
        bridge_en = 1'b1;
        inst_req = 1'b1; inst_wr = 1'b1; inst_size = 2'd0; inst_addr = 32'h0000_4000; inst_wdata = $urandom;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd3; data_addr = 32'h0000_5000; data_wdata = $urandom;
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(1'b1, 1'b0, 2'd3, 32'h0000_5000, data_wdata));
        exp_q.push_back(mk(1'b0, 1'b1, 2'd0, 32'h0000_4000, inst_wdata));
        for (int k = 0; k < 2; k++) exp_q.push_back(mk(1'b1, 1'b0, 2'd3, 32'h0000_5000, data_wdata));
        base_hs = n_data_hs + n_inst_hs; base_i = n_inst_hs; base_done = n_done;
        for (int i = 0; i < 300 && (n_done - base_done) < 7; i++) begin
            step();
            if (n_inst_hs > base_i) inst_req = 1'b0;
            if ((n_data_hs + n_inst_hs - base_hs) >= 7) data_req = 1'b0;
        end
        inst_req = 1'b0; data_req = 1'b0;
        n_checks++;
        if ((n_done - base_done) !== 7) begin
            n_fail++;
            $display("FAIL starve_done: got %0d completions, required 7", n_done - base_done);
        end
        step();
        step();
    endtask

    task automatic test_withdrawn();
        apply_reset();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h0000_6000; data_wdata = $urandom;
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h0000_7000; inst_wdata = $urandom;
        step();
        sample();
        n_checks++;
        if ({dbg_state, bus_req, bus_addr, data_addr_ok} !== {S_ADDR, 1'b1, 32'h0000_6000, 1'b0}) begin
            n_fail++;
            $display("FAIL withdraw_grant: got state=%0d req=%b addr=%h aok=%b, required ADDR/1/00006000/0",
                     dbg_state, bus_req, bus_addr, data_addr_ok);
        end
        next();
        data_req = 1'b0;
        sample();
        n_checks++;
        if ({bus_req, data_addr_ok} !== 2'b00) begin
            n_fail++;
            $display("FAIL withdraw_drop: got req=%b aok=%b, required 0/0", bus_req, data_addr_ok);
        end
        next();
        sample();
        n_checks++;
        if (dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL withdraw_idle: got state=%0d, required %0d", dbg_state, S_IDLE);
        end
        next();
        exp_q.push_back(mk(1'b0, 1'b0, 2'd2, 32'h0000_7000, inst_wdata));
        bus_addr_ok = 1'b1;
        sample();
        n_checks++;
        if ({dbg_state, dbg_owner, inst_addr_ok} !== {S_ADDR, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL withdraw_inst_next: got state=%0d owner=%b iaok=%b, required ADDR/0/1",
                     dbg_state, dbg_owner, inst_addr_ok);
        end
        next();
        bus_addr_ok = 1'b0; inst_req = 1'b0;
        bus_data_ok = 1'b1; bus_rdata = $urandom;
        rd_q.push_back(bus_rdata);
        step();
        bus_data_ok = 1'b0;
        step();
    endtask

    task automatic test_spurious();
        apply_reset();
        bus_data_ok = 1'b1; bus_addr_ok = 1'b1;
        sample();
        n_checks++;
        if ({dbg_state, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== {S_IDLE, 4'b0}) begin
            n_fail++;
            $display("FAIL spurious_idle: got state=%0d oks=%b, required IDLE/0000", dbg_state,
                     {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        end
        next();
        bus_addr_ok = 1'b0;
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h0000_8000; inst_wdata = $urandom;
        step();
        step();
        sample();
        n_checks++;
        if ({dbg_state, bus_req, inst_data_ok, data_data_ok} !== {S_ADDR, 3'b100}) begin
            n_fail++;
            $display("FAIL spurious_addr: got state=%0d req=%b iok=%b dok=%b, required ADDR/1/0/0",
                     dbg_state, bus_req, inst_data_ok, data_data_ok);
        end
        next();
        bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 2'd2, 32'h0000_8000, inst_wdata));
        step();
        bus_addr_ok = 1'b0; inst_req = 1'b0;
        bus_data_ok = 1'b1; bus_rdata = $urandom;
        rd_q.push_back(bus_rdata);
        sample();
        n_checks++;
        if (inst_data_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_real_done: got iok=%b, required 1", inst_data_ok);
        end
        next();
        bus_data_ok = 1'b0;
        step();
    endtask

    task automatic test_reset_in_wait();
        apply_reset();
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_9000; data_wdata = $urandom;
        exp_q.push_back(mk(1'b1, 1'b0, 2'd2, 32'h0000_9000, data_wdata));
        step();
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0; data_req = 1'b0;
        rst = 1'b1; bus_data_ok = 1'b1; bus_rdata = $urandom;
        sample();
        n_checks++;
        if ({data_data_ok, inst_data_ok, bus_req} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstwait_gate: got dok=%b iok=%b req=%b, required 0/0/0", data_data_ok, inst_data_ok, bus_req);
        end
        next();
        rst = 1'b0;
        sample();
        n_checks++;
        if ({dbg_state, dbg_owner, bus_req, data_data_ok, inst_data_ok} !== {S_IDLE, 4'b0}) begin
            n_fail++;
            $display("FAIL rstwait_idle: got state=%0d owner=%b req=%b dok=%b, required IDLE/0/0/0",
                     dbg_state, dbg_owner, bus_req, data_data_ok);
        end
        next();
        sample();
        n_checks++;
        if ({dbg_state, data_data_ok, inst_data_ok} !== {S_IDLE, 2'b00}) begin
            n_fail++;
            $display("FAIL rstwait_late_data_ok: got state=%0d dok=%b iok=%b, required IDLE/0/0",
                     dbg_state, data_data_ok, inst_data_ok);
        end
        next();
        bus_data_ok = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_data_read();
        test_simultaneous();
        test_starvation();
        test_withdrawn();
        test_spurious();
        test_reset_in_wait();
        n_checks++;
        if (exp_q.size() != 0 || rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL queues_drained: got %0d grants and %0d reads pending, required 0 and 0",
                     exp_q.size(), rd_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
